// File: rtl/gray_ptr_fifo_pkg.sv
// gray_ptr_fifo_pkg: shared constants and pointer helpers for the Gray-pointer FIFO
package gray_ptr_fifo_pkg;
  localparam int DEF_DEPTH = 512;
  localparam int DEF_WIDTH = 4;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_ptr_fifo_if.sv
// gray_ptr_fifo_if: producer/consumer handshake bundle for the FIFO
interface gray_ptr_fifo_if #(parameter int W = 4);
  logic i_wen;
  logic [W-1:0] i_wdata;
  logic o_full;
  logic i_ren;
  logic [W-1:0] o_rdata;
  logic o_rempty;
  modport master(output i_wen, i_wdata, i_ren, input o_full, o_rdata, o_rempty);
  modport slave(input i_wen, i_wdata, i_ren, output o_full, o_rdata, o_rempty);
endinterface

// File: rtl/gray_ptr_fifo_ptr_sync.sv
// fifo_ptr_sync: two-flop pointer synchronizer with synchronous reset
module fifo_ptr_sync #(parameter int W = 10) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q1;
  always_ff @(posedge clk)
    if (rst) {q, q1} <= '0;
    else {q, q1} <= {q1, d};
endmodule

// File: rtl/gray_ptr_fifo.sv
// gray_ptr_fifo: single-clock FIFO on the dual-clock Gray-pointer architecture
module gray_ptr_fifo
  import gray_ptr_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int FIFO_WIDTH = DEF_WIDTH
) (
  input logic i_clk,
  input logic i_rst,
  gray_ptr_fifo_if.slave f
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wbin, wgray, rbin, rgray, wq2, rq2, wbin_n, rbin_n;
  logic we, re;
  always_comb begin
    we = f.i_wen & ~f.o_full;
    re = f.i_ren & ~f.o_rempty;
    wbin_n = wbin + PW'(1);
    rbin_n = rbin + PW'(1);
  end
  assign f.o_rempty = rgray == wq2;
  assign f.o_full = wgray == {~rq2[AW:AW-1], rq2[AW-2:0]};
  always_ff @(posedge i_clk)
    if (i_rst) begin
      wbin <= '0;
      wgray <= '0;
    end else if (we) begin
      wbin <= wbin_n;
      wgray <= PW'(bin2gray(32'(wbin_n)));
    end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      rbin <= '0;
      rgray <= '0;
      f.o_rdata <= '0;
    end else if (re) begin
      rbin <= rbin_n;
      rgray <= PW'(bin2gray(32'(rbin_n)));
      f.o_rdata <= mem[rbin[AW-1:0]];
    end
  always_ff @(posedge i_clk)
    if (we && !i_rst) mem[wbin[AW-1:0]] <= f.i_wdata;
  fifo_ptr_sync #(.W(PW)) u_w2r (.clk(i_clk), .rst(i_rst), .d(wgray), .q(wq2));
  fifo_ptr_sync #(.W(PW)) u_r2w (.clk(i_clk), .rst(i_rst), .d(rgray), .q(rq2));
endmodule

// File: tb/tb_gray_ptr_fifo.sv
// tb_gray_ptr_fifo: table vectors, corner sequences and random traffic against a queue model
module tb_gray_ptr_fifo;
  localparam int D = 512;
  localparam int W = 4;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  gray_ptr_fifo_if #(.W(W)) f();
  gray_ptr_fifo #(.FIFO_DEPTH(D), .FIFO_WIDTH(W)) dut (.i_clk(clk), .i_rst(rst), .f(f));
  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_rdata = '0;
  int nw = 0, nr = 0, w1 = 0, w2 = 0, r1 = 0, r2 = 0;
  typedef struct {
    logic w, r, s;
    logic [W-1:0] d;
    logic e, fl;
    logic [W-1:0] rd;
  } vec_t;
  vec_t tv[6];
  function automatic bit m_empty();
    return nr == w2;
  endfunction
  function automatic bit m_full();
    return nw - r2 == D;
  endfunction
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, a, e);
    end
  endtask
  task automatic step(input logic wv, input logic rv, input logic sv, input logic [W-1:0] d);
    bit wa, ra;
    f.i_wen = wv;
    f.i_ren = rv;
    f.i_wdata = d;
    rst = sv;
    wa = wv && !m_full();
    ra = rv && !m_empty();
    @(posedge clk);
    if (sv) begin
      q.delete();
      {nw, nr, w1, w2, r1, r2} = '0;
      m_rdata = '0;
    end else begin
      w2 = w1; w1 = nw; r2 = r1; r1 = nr;
      if (ra) begin m_rdata = q.pop_front(); nr++; end
      if (wa) begin q.push_back(d); nw++; end
    end
    @(negedge clk);
    chk("rempty", int'(f.o_rempty), int'(m_empty()));
    chk("full", int'(f.o_full), int'(m_full()));
    chk("rdata", int'(f.o_rdata), int'(m_rdata));
  endtask
  initial begin
    f.i_wen = 0; f.i_ren = 0; f.i_wdata = '0;
    tv[0] = '{w:1'b1, r:1'b1, s:1'b1, d:4'h3, e:1'b1, fl:1'b0, rd:4'h0};
    tv[1] = '{w:1'b1, r:1'b1, s:1'b0, d:4'hA, e:1'b1, fl:1'b0, rd:4'h0};
    tv[2] = '{w:1'b0, r:1'b1, s:1'b0, d:4'h0, e:1'b1, fl:1'b0, rd:4'h0};
    tv[3] = '{w:1'b0, r:1'b1, s:1'b0, d:4'h0, e:1'b0, fl:1'b0, rd:4'h0};
    tv[4] = '{w:1'b0, r:1'b1, s:1'b0, d:4'h0, e:1'b1, fl:1'b0, rd:4'hA};
    tv[5] = '{w:1'b0, r:1'b1, s:1'b0, d:4'h0, e:1'b1, fl:1'b0, rd:4'hA};
    for (int i = 0; i < 2; i++) begin
      step(1'($urandom), 1'($urandom), 1'b1, W'($urandom));
      chk("rst_empty", int'(f.o_rempty), 1);
      chk("rst_full", int'(f.o_full), 0);
      chk("rst_rdata", int'(f.o_rdata), 0);
      chk("rst_wbin", int'(dut.wbin), 0);
      chk("rst_rbin", int'(dut.rbin), 0);
    end
    for (int i = 0; i < 6; i++) begin
      step(tv[i].w, tv[i].r, tv[i].s, tv[i].d);
      chk($sformatf("tv%0d_empty", i), int'(f.o_rempty), int'(tv[i].e));
      chk($sformatf("tv%0d_full", i), int'(f.o_full), int'(tv[i].fl));
      chk($sformatf("tv%0d_rdata", i), int'(f.o_rdata), int'(tv[i].rd));
    end
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, W'(i));
    chk("fill_full", int'(f.o_full), 1);
    step(1'b1, 1'b0, 1'b0, 4'hF);
    chk("overflow_full", int'(f.o_full), 1);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk("drain_data", int'(f.o_rdata), i % 16);
    end
    chk("drain_empty", int'(f.o_rempty), 1);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("underflow_rdata", int'(f.o_rdata), 4'hF);
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, W'($urandom));
    step(1'b0, 1'b0, 1'b0, '0);
    chk("refill_full", int'(f.o_full), 1);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("release_k", int'(f.o_full), 1);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("release_k1", int'(f.o_full), 1);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("release_k2", int'(f.o_full), 0);
    step(1'b1, 1'b0, 1'b0, 4'h7);
    chk("one_write_full", int'(f.o_full), 1);
    step(1'b1, 1'b0, 1'b0, 4'h9);
    chk("extra_write_count", nw, 2 * D + 2);
    for (int i = 0; i < D + 4; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("release_drained", int'(f.o_rempty), 1);
    for (int i = 0; i < 2000; i++) step(1'($urandom), 1'($urandom), 1'b0, W'($urandom));
    for (int i = 0; i < 4000; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("random_empty", int'(f.o_rempty), 1);
    chk("random_model_empty", q.size(), 0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, W'($urandom));
    step(1'b0, 1'b0, 1'b1, '0);
    chk("midrst_empty", int'(f.o_rempty), 1);
    chk("midrst_full", int'(f.o_full), 0);
    chk("midrst_rdata", int'(f.o_rdata), 0);
    step(1'b1, 1'b0, 1'b0, 4'h5);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("midrst_readback", int'(f.o_rdata), 5);
    chk("midrst_final_empty", int'(f.o_rempty), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
